nmea_tx_arbiter: RTL and testbench

//  Sequences the shared uart transmitter for GPS/NMEA traffic. Two byte-stream requesters
//  (0: GPS sentence source, 1: command/config source) compete for one uart tx. Grant is locked
//  per NMEA sentence ('$' 0x24 .. LF 0x0A) so sentences never interleave. Drives the uart's

---
 rtl/gps_uart_pkg.sv | 36 +++
 rtl/nmea_rr_arbiter.sv | 56 +++++
 rtl/nmea_tx_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_nmea_tx_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gps_uart_pkg.sv
// Shared definitions for the GPS/NMEA uart transmit path.
//   state_e     : transmit sequencer states
//   NMEA_*      : framing bytes of an NMEA sentence
//   next_lock() : sentence-lock update for one accepted byte
package gps_uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_e;

  localparam logic [7:0] NMEA_START = 8'h24;
  localparam logic [7:0] NMEA_LF    = 8'h0A;
  localparam logic [7:0] NMEA_CR    = 8'h0D;

  // '$' opens a sentence, LF closes it; CR precedes LF, so the lock stays
  // up until the LF itself has been accepted.
  function automatic logic next_lock(input logic cur, input logic [7:0] b);
    logic nl;
    nl = cur;
    if (b == NMEA_START) begin
      nl = 1'b1;
    end else if (b == NMEA_LF) begin
      nl = 1'b0;
    end else if (b == NMEA_CR) begin
      nl = cur;
    end else begin
      nl = cur;
    end
    return nl;
  endfunction

endpackage

// File: rtl/nmea_rr_arbiter.sv
// Two-way round-robin arbiter with a sentence-lock mask.
//   clk, rst_n  : clock, asynchronous active-low reset
//   arb_en      : arbitration window open (sequencer idle)
//   lock_en     : sentence lock active; only last_owner is eligible
//   req0_valid  : requester 0 has a byte
//   req1_valid  : requester 1 has a byte
//   gnt_valid   : a requester is granted this cycle (combinational)
//   gnt_id      : which requester is granted (combinational)
//   last_owner  : registered id of the most recent grant (resets to 1)
module nmea_rr_arbiter
  import gps_uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic lock_en,
  input  logic req0_valid,
  input  logic req1_valid,
  output logic gnt_valid,
  output logic gnt_id,
  output logic last_owner
);

  logic elig0_s;
  logic elig1_s;
  logic last_owner_r;

  // Lock masks out the non-owner; on a tie the requester that did not go last wins.
  always_comb begin
    elig0_s   = req0_valid & (~lock_en | ~last_owner_r);
    elig1_s   = req1_valid & (~lock_en | last_owner_r);
    gnt_id    = 1'b0;
    if (elig0_s & elig1_s) begin
      gnt_id = ~last_owner_r;
    end else if (elig1_s) begin
      gnt_id = 1'b1;
    end else begin
      gnt_id = 1'b0;
    end
    gnt_valid = arb_en & (elig0_s | elig1_s);
  end

  // Remember the most recent winner; reset value 1 makes req0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_r <= 1'b1;
    end else if (gnt_valid) begin
      last_owner_r <= gnt_id;
    end else begin
      last_owner_r <= last_owner_r;
    end
  end

  assign last_owner = last_owner_r;

endmodule

// File: rtl/nmea_tx_arbiter.sv
// Shares one uart transmitter between a GPS sentence source (req0) and a
// command/config source (req1). A grant is locked for a whole NMEA sentence
// ('$' .. LF) so sentences never interleave; bytes are paced on tx_busy.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req0_valid/data/ready : requester 0 byte stream (ready = accepted this cycle)
//   req1_valid/data/ready : requester 1 byte stream
//   tx_data               : byte to the uart, stable from LOAD onwards
//   tx_load               : one-cycle load strobe
//   tx_send               : send request, held until tx_busy seen
//   tx_busy               : uart busy
//   grant_id              : current/last owner
//   locked                : sentence lock active
//   err_busy_to           : pulse, uart never went busy within BUSY_WAIT
//   err_lock_to           : pulse, lock dropped after LOCK_TIMEOUT idle clocks
//   bytes_sent            : completed bytes, wrapping
module nmea_tx_arbiter
  import gps_uart_pkg::*;
#(
  parameter int GAP_CYCLES   = 16,
  parameter int BUSY_WAIT    = 64,
  parameter int LOCK_TIMEOUT = 32768
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic [7:0]  tx_data,
  output logic        tx_load,
  output logic        tx_send,
  input  logic        tx_busy,
  output logic        grant_id,
  output logic        locked,
  output logic        err_busy_to,
  output logic        err_lock_to,
  output logic [15:0] bytes_sent
);

  localparam int BW = $clog2(BUSY_WAIT) + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam int LW = $clog2(LOCK_TIMEOUT) + 1;

  localparam logic [BW-1:0] BUSY_LAST = BW'(BUSY_WAIT - 1);
  localparam logic [BW-1:0] BUSY_ONE  = BW'(1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] GAP_ONE   = GW'(1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_TIMEOUT - 1);
  localparam logic [LW-1:0] LOCK_ONE  = LW'(1);

  state_e        state_r;
  state_e        state_s;
  logic [BW-1:0] busy_cnt_r;
  logic [GW-1:0] gap_cnt_r;
  logic [LW-1:0] lock_cnt_r;
  logic [7:0]    hold_r;
  logic          tx_load_r;
  logic          tx_send_r;
  logic          grant_id_r;
  logic          locked_r;
  logic          err_busy_to_r;
  logic          err_lock_to_r;
  logic [15:0]   bytes_sent_r;

  logic          gnt_valid_s;
  logic          gnt_id_s;
  logic          last_owner_s;
  logic          accept_s;
  logic [7:0]    acc_data_s;
  logic          owner_valid_s;
  logic          lock_stall_s;
  logic          lock_to_s;
  logic          busy_to_s;
  logic          byte_done_s;
  logic          locked_s;

  // Arbitration is only open in IDLE; the lock owner is always last_owner.
  nmea_rr_arbiter u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .arb_en     (state_r == IDLE),
    .lock_en    (locked_r),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .gnt_valid  (gnt_valid_s),
    .gnt_id     (gnt_id_s),
    .last_owner (last_owner_s)
  );

  assign accept_s   = gnt_valid_s;
  assign acc_data_s = gnt_id_s ? req1_data : req0_data;
  assign req0_ready = gnt_valid_s & ~gnt_id_s;
  assign req1_ready = gnt_valid_s & gnt_id_s;

  // Next-state decode, timeout detection and lock update.
  always_comb begin
    state_s       = state_r;
    busy_to_s     = 1'b0;
    byte_done_s   = 1'b0;
    locked_s      = locked_r;
    owner_valid_s = last_owner_s ? req1_valid : req0_valid;
    lock_stall_s  = (state_r == IDLE) & locked_r & ~owner_valid_s;
    lock_to_s     = lock_stall_s & (lock_cnt_r == LOCK_LAST);

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        state_s = SEND;
      end
      SEND: begin
        if (tx_busy) begin
          state_s = WAIT_DONE;
        end else if (busy_cnt_r == BUSY_LAST) begin
          state_s   = IDLE;
          busy_to_s = 1'b1;
        end else begin
          state_s = SEND;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_s     = GAP;
          byte_done_s = 1'b1;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_s = IDLE;
        end else begin
          state_s = GAP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // A lost byte or a stalled owner both abandon the sentence.
    if (lock_to_s || busy_to_s) begin
      locked_s = 1'b0;
    end else if (accept_s) begin
      locked_s = next_lock(locked_r, acc_data_s);
    end else begin
      locked_s = locked_r;
    end
  end

  // State register and registered uart-side / status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      hold_r        <= 8'h00;
      tx_load_r     <= 1'b0;
      tx_send_r     <= 1'b0;
      grant_id_r    <= 1'b0;
      locked_r      <= 1'b0;
      err_busy_to_r <= 1'b0;
      err_lock_to_r <= 1'b0;
      bytes_sent_r  <= 16'h0000;
    end else begin
      state_r       <= state_s;
      tx_load_r     <= accept_s;
      tx_send_r     <= (state_s == SEND);
      err_busy_to_r <= busy_to_s;
      err_lock_to_r <= lock_to_s;
      locked_r      <= locked_s;
      if (accept_s) begin
        hold_r     <= acc_data_s;
        grant_id_r <= gnt_id_s;
      end
      if (byte_done_s) begin
        bytes_sent_r <= bytes_sent_r + 16'd1;
      end
    end
  end

  // Busy-wait, inter-byte gap and lock-stall timers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt_r <= {BW{1'b0}};
      gap_cnt_r  <= {GW{1'b0}};
      lock_cnt_r <= {LW{1'b0}};
    end else begin
      if ((state_r == SEND) && (state_s == SEND)) begin
        busy_cnt_r <= busy_cnt_r + BUSY_ONE;
      end else begin
        busy_cnt_r <= {BW{1'b0}};
      end
      if ((state_r == GAP) && (state_s == GAP)) begin
        gap_cnt_r <= gap_cnt_r + GAP_ONE;
      end else begin
        gap_cnt_r <= {GW{1'b0}};
      end
      // While locked only the owner can be accepted, so any accept clears it.
      if (!locked_r || accept_s || lock_to_s) begin
        lock_cnt_r <= {LW{1'b0}};
      end else if (lock_stall_s) begin
        lock_cnt_r <= lock_cnt_r + LOCK_ONE;
      end else begin
        lock_cnt_r <= lock_cnt_r;
      end
    end
  end

  assign tx_data     = hold_r;
  assign tx_load     = tx_load_r;
  assign tx_send     = tx_send_r;
  assign grant_id    = grant_id_r;
  assign locked      = locked_r;
  assign err_busy_to = err_busy_to_r;
  assign err_lock_to = err_lock_to_r;
  assign bytes_sent  = bytes_sent_r;

endmodule

// File: tb/tb_nmea_tx_arbiter.sv
// Directed bench for nmea_tx_arbiter with a simple uart model
// (busy for 10 bit-times of 4 clocks once tx_send is seen).
module tb_nmea_tx_arbiter;

  localparam int BUSY_CLKS = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0;
  logic [7:0]  req0_data = 8'h00;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [7:0]  req1_data = 8'h00;
  logic        req1_ready;
  logic [7:0]  tx_data;
  logic        tx_load;
  logic        tx_send;
  logic        tx_busy;
  logic        grant_id;
  logic        locked;
  logic        err_busy_to;
  logic        err_lock_to;
  logic [15:0] bytes_sent;

  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic        uart_dead = 1'b0;
  int          acc0_n = 0;
  int          acc1_n = 0;
  int          log_n = 0;
  logic [7:0]  log_data [0:127];
  logic        log_lock [0:127];
  logic        log_gid  [0:127];
  int          n_cmp = 0;
  int          n_err = 0;

  nmea_tx_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .tx_send     (tx_send),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .locked      (locked),
    .err_busy_to (err_busy_to),
    .err_lock_to (err_lock_to),
    .bytes_sent  (bytes_sent)
  );

  always #5 clk = ~clk;

  // uart model plus a log of every loaded byte (data, lock and owner at LOAD)
  always @(posedge clk) begin
    if (tx_load && log_n < 128) begin
      log_data[log_n] <= tx_data;
      log_lock[log_n] <= locked;
      log_gid[log_n]  <= grant_id;
      log_n           <= log_n + 1;
    end
    if (m_busy) begin
      if (m_cnt <= 1) m_busy <= 1'b0;
      m_cnt <= m_cnt - 1;
    end else if (tx_send && !uart_dead) begin
      m_busy <= 1'b1;
      m_cnt  <= BUSY_CLKS;
    end
  end
  assign tx_busy = m_busy;

  // accept counters (valid & ready at the clock edge)
  always @(posedge clk) begin
    if (req0_valid && req0_ready) acc0_n <= acc0_n + 1;
    if (req1_valid && req1_ready) acc1_n <= acc1_n + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present each byte of s on one requester until it is accepted.
  task automatic send_str(input bit port, input string s);
    @(negedge clk);
    for (int i = 0; i < s.len(); i++) begin
      int base;
      int n;
      if (port) begin
        req1_data = s[i]; req1_valid = 1'b1; base = acc1_n;
      end else begin
        req0_data = s[i]; req0_valid = 1'b1; base = acc0_n;
      end
      n = 0;
      while (((port ? acc1_n : acc0_n) == base) && n < 40000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 40000) check_val(port ? "accept1_timeout" : "accept0_timeout", 32'd0, 32'd1);
    end
    if (port) req1_valid = 1'b0;
    else      req0_valid = 1'b0;
  endtask

  task automatic wait_bytes(input string tag, input int target);
    int n;
    n = 0;
    while (int'(bytes_sent) != target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 32'(bytes_sent), 32'(target));
  endtask

  task automatic check_log(input string tag, input int st, input string exp_d, input string exp_g);
    for (int i = 0; i < exp_d.len(); i++) begin
      check_val({tag, "_data"}, 32'(log_data[st + i]), 32'(exp_d[i]));
      check_val({tag, "_gid"}, 32'(log_gid[st + i]), (exp_g[i] == "1") ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int    st;
    int    a0;
    int    b0;
    int    n5;
    int    n6;
    string msg;

    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_outputs", 32'({tx_data, tx_load, tx_send, grant_id, locked,
                                  err_busy_to, err_lock_to, bytes_sent}), 32'd0);

    // ---------------- 2: round robin, unlocked ----------------
    st = log_n;
    fork
      send_str(1'b0, "ac");
      send_str(1'b1, "bd");
    join
    wait_bytes("t2_bytes", 4);
    check_log("t2", st, "abcd", "0101");

    // ---------------- 1: full sentence on req0 ----------------
    msg = "$GPGGA,...*71\r\n";
    st  = log_n;
    send_str(1'b0, msg);
    wait_bytes("t1_bytes", 4 + msg.len());
    for (int i = 0; i < msg.len(); i++) begin
      check_val("t1_data", 32'(log_data[st + i]), 32'(msg[i]));
      check_val("t1_lock", 32'(log_lock[st + i]), (i == msg.len() - 1) ? 32'd0 : 32'd1);
    end
    check_val("t1_loads", 32'(log_n - st), 32'(msg.len()));
    check_val("t1_unlocked", 32'(locked), 32'd0);

    // ---------------- 3: req1 held off during req0 sentence ----------------
    st = log_n;
    a0 = acc0_n;
    fork
      send_str(1'b0, "$GP\n");
      begin : t3_req1
        int n3;
        n3 = 0;
        while (acc0_n == a0 && n3 < 1000) begin @(negedge clk); n3++; end
        send_str(1'b1, "X");
      end
    join
    wait_bytes("t3_bytes", 24);
    check_log("t3", st, "$GP\nX", "00001");
    check_val("t3_lock_mid", 32'(log_lock[st + 2]), 32'd1);

    // ---------------- 4: uart never goes busy ----------------
    b0        = int'(bytes_sent);
    uart_dead = 1'b1;
    a0        = acc0_n;
    fork
      send_str(1'b0, "$");
      begin : t4_req1
        int n4;
        n4 = 0;
        while (acc0_n == a0 && n4 < 1000) begin @(negedge clk); n4++; end
        send_str(1'b1, "Z");
      end
      begin : t4_measure
        int w4;
        int c4;
        w4 = 0;
        while (!tx_send && w4 < 500) begin @(negedge clk); w4++; end
        c4 = 0;
        while (tx_send && c4 < 500) begin c4++; @(negedge clk); end
        check_val("t4_send_len", 32'(c4), 32'd64);
        check_val("t4_err_busy_to", 32'(err_busy_to), 32'd1);
        check_val("t4_unlocked", 32'(locked), 32'd0);
        check_val("t4_idle_req1_ready", 32'(req1_ready), 32'd1);
        uart_dead = 1'b0;
      end
    join
    wait_bytes("t4_bytes", b0 + 1);
    check_log("t4", log_n - 1, "Z", "1");

    // ---------------- 5: owner stalls mid-sentence ----------------
    send_str(1'b0, "$G");
    n5 = 0;
    fork
      send_str(1'b1, "Q");
      begin : t5_measure
        while (!err_lock_to && n5 < 40000) begin @(negedge clk); n5++; end
        check_val("t5_lock_to_window", 32'(n5 >= 32768 && n5 <= 32900), 32'd1);
        check_val("t5_unlocked", 32'(locked), 32'd0);
        check_val("t5_req1_ready", 32'(req1_ready), 32'd1);
      end
    join
    wait_bytes("t5_bytes", b0 + 4);
    check_log("t5", log_n - 1, "Q", "1");

    // ---------------- 6: reset during WAIT_DONE ----------------
    send_str(1'b0, "$");
    n6 = 0;
    while (!tx_busy && n6 < 200) begin @(negedge clk); n6++; end
    @(negedge clk);
    check_val("t6_locked_pre", 32'(locked), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_async_outputs", 32'({tx_data, tx_load, tx_send, grant_id, locked,
                                       err_busy_to, err_lock_to}), 32'd0);
    check_val("t6_async_bytes", 32'(bytes_sent), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("t6_bytes_after_rst", 32'(bytes_sent), 32'd0);
    st = log_n;
    fork
      send_str(1'b0, "a");
      send_str(1'b1, "b");
    join
    wait_bytes("t6_bytes", 2);
    check_log("t6", st, "ab", "01");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
